sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Input-side conditioner for a board slide switch or pushbutton that feeds
//    logic or an LED driver.
//  Synchronises the raw asynchronous Sw pin into Clk, rejects contact bounce
//    shorter than STABLE_CYCLES, and presents:
//    - a clean level
//    - single-cycle Rise/Fall event pulses
//    - a press-toggled state.
// PARAMETERS
//  STABLE_CYCLES  1000000  consecutive cycles of a new level required to accept it (10 ms @ 100 MHz); legal >= 2
//  RESET_LEVEL    0        value taken by synchroniser flops and Sw_Level in reset
//  CNT_W          $clog2(STABLE_CYCLES)  localparam, counter width; not overridable
// PORTS
//  Clk       input   1  system clock; all logic on rising edge
//  Rst_n     input   1  reset, synchronous, active-low
//  Sw        input   1  raw switch pin, asynchronous to Clk, may bounce
//  Sw_Level  output  1  debounced switch level
//  Rise      output  1  one-cycle pulse when Sw_Level goes 0->1
//  Fall      output  1  one-cycle pulse when Sw_Level goes 1->0
//  Toggle    output  1  inverts on every Rise (press-to-toggle state)
//  Busy      output  1  high while a candidate level change is being timed
// BEHAVIOUR
//  Reset (Rst_n low at a Clk edge):
//    - sync1, sync2, Sw_Level <= RESET_LEVEL
//    - cnt <= 0; Rise, Fall, Toggle, Busy <= 0; state <= STABLE
//    - reset overrides all other activity
//  Synchroniser: two flops, sync1 <= Sw, sync2 <= sync1. Only sync2 is used downstream.
//  FSM states:
//    STABLE:
//      - sync2 == Sw_Level: hold, cnt stays 0
//      - sync2 != Sw_Level: cnt <= 1, go to COUNTING
//    COUNTING:
//      - sync2 == Sw_Level (bounce): cnt <= 0, go to STABLE, no output change
//      - sync2 != Sw_Level and cnt == STABLE_CYCLES-1: Sw_Level <= sync2, cnt <= 0, go to STABLE
//      - otherwise: cnt <= cnt+1
//  Latency:
//    - a clean Sw change sampled at edge k sets Sw_Level at edge k+1+STABLE_CYCLES
//    - with STABLE_CYCLES=4: sampled at edge 1, level changes at edge 6
//  Busy == (state == COUNTING), registered.
//  Rise/Fall:
//    - registered; asserted on the same edge that updates Sw_Level, cleared on the next edge
//    - never both high; never asserted outside a Sw_Level change
//  Toggle <= ~Toggle on the edge where Rise is set, so the new Toggle value and Rise appear together.
//  Boundaries:
//    - cnt never exceeds STABLE_CYCLES-1, so no wrap
//    - a bounce back on the final counting cycle still rejects the change
//    - reset mid-count discards the pending change and produces no pulse
//    - Sw equal to RESET_LEVEL across reset release produces no event
// TESTING (bench uses STABLE_CYCLES=4, RESET_LEVEL=0)
//  1. Rst_n low 3 cycles, Sw=0, then release -> all outputs 0 and stay 0 for 20 cycles
//  2. Sw 0->1 sampled at edge 1, held -> Sw_Level=1 at edge 6; Rise high only edges 6-7; Toggle=1; Busy high edges 3-6
//  3. Sw high 3 cycles then low (bounce) -> Sw_Level, Rise, Toggle unchanged; Busy rises, then clears once sync2 returns to 0
//  4. From stable Sw_Level=1, Sw->0 held 10 cycles -> one Fall pulse, Sw_Level=0, Toggle unchanged, no Rise
//  5. Sw 0->1, Rst_n pulsed low while Busy=1 -> cnt=0, Sw_Level=0, no Rise; with Sw still 1 after release, Rise follows 5 edges later
//  6. Two clean press/release cycles -> exactly two Rise and two Fall pulses; Toggle ends at 0

Source files
------------

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//
// Input-side conditioner for a board slide switch or pushbutton.
// The raw, asynchronous, bouncing switch pin is brought into the Clk domain
// through a two-flop synchroniser. A new level is accepted only after it has
// been seen for STABLE_CYCLES consecutive cycles. The module then presents
// a clean level, one-cycle edge pulses and a press-toggled state.
//
// Parameters
//   STABLE_CYCLES : consecutive cycles a new level must persist (>= 2)
//   RESET_LEVEL   : value of the synchroniser flops and Sw_Level in reset
//
// Ports
//   Clk      in   system clock, all logic on the rising edge
//   Rst_n    in   synchronous, active-low reset
//   Sw       in   raw switch pin (asynchronous, may bounce)
//   Sw_Level out  debounced switch level
//   Rise     out  one-cycle pulse when Sw_Level goes 0->1
//   Fall     out  one-cycle pulse when Sw_Level goes 1->0
//   Toggle   out  inverts on every Rise (press-to-toggle state)
//   Busy     out  high while a candidate level change is being timed
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int   STABLE_CYCLES = 1000000,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Sw,
  output logic Sw_Level,
  output logic Rise,
  output logic Fall,
  output logic Toggle,
  output logic Busy
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);

  // Terminal count: the new level has been seen for STABLE_CYCLES cycles
  // once the counter sits here and sync2 still disagrees with Sw_Level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser. Stage 0 samples the pin, stage 1 (sync2) is the
  // only value the rest of the logic looks at.
  // -------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  assign sync_d[0] = Sw;

  genvar gi;
  generate
    for (gi = 1; gi < 2; gi++) begin : g_sync_chain
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync_ff
      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          sync_q[gi] <= RESET_LEVEL;
        end else begin
          sync_q[gi] <= sync_d[gi];
        end
      end
    end
  endgenerate

  logic sync2;
  assign sync2 = sync_q[1];

  // -------------------------------------------------------------------------
  // Debounce FSM state and output registers
  // -------------------------------------------------------------------------
  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             level_q,  level_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic             toggle_q, toggle_d;
  logic             busy_q,   busy_d;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;

    case (state_q)
      ST_STABLE: begin
        if (sync2 != level_q) begin
          // First cycle of the candidate level counts as one.
          cnt_d   = CNT_W'(1);
          state_d = ST_COUNTING;
        end else begin
          cnt_d = '0;
        end
      end

      ST_COUNTING: begin
        if (sync2 == level_q) begin
          // Bounced back, including on the very last counting cycle:
          // drop the candidate without touching any output.
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          // Accept the new level; pulses and Toggle update on the same edge.
          level_d  = sync2;
          cnt_d    = '0;
          state_d  = ST_STABLE;
          rise_d   = sync2;
          fall_d   = ~sync2;
          toggle_d = toggle_q ^ sync2;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy is registered alongside the state, so it mirrors state == COUNTING.
  assign busy_d = (state_d == ST_COUNTING);

  assign Sw_Level = level_q;
  assign Rise     = rise_q;
  assign Fall     = fall_q;
  assign Toggle   = toggle_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//
// Self-checking bench for sw_debounce with STABLE_CYCLES=4, RESET_LEVEL=0.
// Run-length stimulus records {Rst_n, Sw, repeat count, expected outputs}
// are applied one cycle at a time; the expected outputs for each cycle are
// pushed to a queue when the inputs are driven and popped and compared just
// after the following rising edge. A hand-written press/release sequence
// checks pulse counts and the final Toggle value.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

  logic clk;
  logic rst_n;
  logic sw;
  logic sw_level;
  logic rise;
  logic fall;
  logic toggle;
  logic busy;

  sw_debounce #(
    .STABLE_CYCLES (4),
    .RESET_LEVEL   (1'b0)
  ) dut (
    .Clk      (clk),
    .Rst_n    (rst_n),
    .Sw       (sw),
    .Sw_Level (sw_level),
    .Rise     (rise),
    .Fall     (fall),
    .Toggle   (toggle),
    .Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
    logic tog;
    logic busy;
  } exp_t;

  typedef struct {
    logic rst_n;
    logic sw;
    int   reps;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   cyc;

  function automatic void add(input logic r, input logic s, input int n,
                              input logic l, input logic ri, input logic fa,
                              input logic t, input logic b);
    vec_t v;
    v.rst_n    = r;
    v.sw       = s;
    v.reps     = n;
    v.exp.lvl  = l;
    v.exp.rise = ri;
    v.exp.fall = fa;
    v.exp.tog  = t;
    v.exp.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic r, input logic s, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst_n = r;
    sw    = s;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sb_q.pop_front();
    chk("sw_level", sw_level, got.lvl);
    chk("rise",     rise,     got.rise);
    chk("fall",     fall,     got.fall);
    chk("toggle",   toggle,   got.tog);
    chk("busy",     busy,     got.busy);
    $display("cycle %0d rst_n=%b sw=%b -> lvl=%b rise=%b fall=%b tog=%b busy=%b",
             cyc, r, s, sw_level, rise, fall, toggle, busy);
  endtask

  initial begin
    int rise_cnt;
    int fall_cnt;
    logic both_seen;

    rst_n  = 1'b0;
    sw     = 1'b0;
    checks = 0;
    errors = 0;
    cyc    = 0;

    //   rst sw  n   lvl ri fa tog busy
    // Reset with Sw=0, release, everything stays quiet.
    add(0, 0,  3,  0, 0, 0, 0, 0);
    add(1, 0, 20,  0, 0, 0, 0, 0);
    // Clean 0->1: level and Rise at edge 6, Busy after edges 3..5.
    add(1, 1,  2,  0, 0, 0, 0, 0);
    add(1, 1,  3,  0, 0, 0, 0, 1);
    add(1, 1,  1,  1, 1, 0, 1, 0);
    add(1, 1,  4,  1, 0, 0, 1, 0);
    // Clean 1->0 held 10 cycles: one Fall, Toggle unchanged.
    add(1, 0,  2,  1, 0, 0, 1, 0);
    add(1, 0,  3,  1, 0, 0, 1, 1);
    add(1, 0,  1,  0, 0, 1, 1, 0);
    add(1, 0,  4,  0, 0, 0, 1, 0);
    // Bounce: high 3 cycles then low; sync2 drops on the final counting cycle.
    add(1, 1,  2,  0, 0, 0, 1, 0);
    add(1, 1,  1,  0, 0, 0, 1, 1);
    add(1, 0,  2,  0, 0, 0, 1, 1);
    add(1, 0,  5,  0, 0, 0, 1, 0);
    // Reset mid-count, Sw stays 1: pending change dropped, Rise 5 edges later.
    add(1, 1,  2,  0, 0, 0, 1, 0);
    add(1, 1,  2,  0, 0, 0, 1, 1);
    add(0, 1,  1,  0, 0, 0, 0, 0);
    add(1, 1,  2,  0, 0, 0, 0, 0);
    add(1, 1,  3,  0, 0, 0, 0, 1);
    add(1, 1,  1,  1, 1, 0, 1, 0);
    add(1, 1,  2,  1, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        step(vecs[i].rst_n, vecs[i].sw, vecs[i].exp);
      end
    end

    // Two clean press/release cycles from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    sw    = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    rise_cnt  = 0;
    fall_cnt  = 0;
    both_seen = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        sw = (p % 2 == 0) ? 1'b1 : 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (rise) rise_cnt++;
        if (fall) fall_cnt++;
        if (rise && fall) both_seen = 1'b1;
      end
      $display("press phase %0d sw=%b -> lvl=%b tog=%b rises=%0d falls=%0d",
               p, sw, sw_level, toggle, rise_cnt, fall_cnt);
      chk("phase_level", sw_level, (p % 2 == 0) ? 1'b1 : 1'b0);
    end
    checks++;
    if (rise_cnt != 2) begin
      errors++;
      $display("FAIL rise_count actual=%0d required=2", rise_cnt);
    end
    checks++;
    if (fall_cnt != 2) begin
      errors++;
      $display("FAIL fall_count actual=%0d required=2", fall_cnt);
    end
    chk("rise_fall_overlap", both_seen, 1'b0);
    chk("final_toggle", toggle, 1'b0);
    chk("final_level", sw_level, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
